apb_lf_master_mux: RTL and testbench

Destination-clock half of the APB asynchronous bridge, generalised. It receives a toggle-encoded request from the source domain through a configurable synchronizer and registers the transfer fields. It decodes the target among NUM_SLV APB completers and runs a standard SETUP/ACCESS sequence. It then returns read data and PSLVERR status to the source domain with a toggle-encoded completion.

---
 rtl/apb_lf_master_mux.sv | 176 +++++++++++++++++
 tb/tb_apb_lf_master_mux.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_lf_master_mux.sv
// Destination-clock half of the APB async bridge: synchronises the request toggle, runs SETUP/ACCESS
// on one of NUM_SLV completers and returns a completion toggle. Optional access timeout: APB_TIMEOUT_EN.
module apb_lf_master_mux #(
    parameter int ADDR_WD     = 32,
    parameter int DATA_WD     = 32,
    parameter int STRB_WD     = 4,
    parameter int PROT_WD     = 3,
    parameter int NUM_SLV     = 4,
    parameter int SLV_LSB     = 12,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                       b_pclk,
    input  logic                       b_prst_n,
    input  logic                       a_apb_req,
    input  logic                       write,
    input  logic [ADDR_WD-1:0]         addr,
    input  logic [DATA_WD-1:0]         wdata,
    input  logic [PROT_WD-1:0]         prot,
    input  logic [STRB_WD-1:0]         strb,
    output logic [NUM_SLV-1:0]         b_psel,
    output logic                       b_penable,
    output logic                       b_pwrite,
    output logic [ADDR_WD-1:0]         b_paddr,
    output logic [DATA_WD-1:0]         b_pwdata,
    output logic [PROT_WD-1:0]         b_pprot,
    output logic [STRB_WD-1:0]         b_pstrb,
    input  logic [NUM_SLV*DATA_WD-1:0] b_prdata,
    input  logic [NUM_SLV-1:0]         b_pready,
    input  logic [NUM_SLV-1:0]         b_pslverr,
    output logic                       b_ready_req,
    output logic [DATA_WD-1:0]         rdata,
    output logic                       slverr
);

    localparam int SEL_WD = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

    state_t               state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 dly_q;
    logic                 req_edge;
    logic                 pend_q, pend_nxt;
    logic [SEL_WD-1:0]    idx_q;
    logic [SEL_WD-1:0]    idx_in;
    logic                 idx_ok;
    logic                 capture, complete, cpl_err, cpl_rd;
    logic                 sel_ready, sel_err;
    logic [DATA_WD-1:0]   sel_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int TO_WD = $clog2(TIMEOUT_CYC + 1);
    logic [TO_WD-1:0]     to_cnt;
`endif

    assign req_edge = sync_q[SYNC_STAGES-1] ^ dly_q;
    assign idx_in   = addr[SLV_LSB +: SEL_WD];
    assign idx_ok   = (32'(idx_in) < NUM_SLV);

    // Only the addressed completer's handshake and data are looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (32'(idx_q) == i) begin
                sel_ready = b_pready[i];
                sel_err   = b_pslverr[i];
                sel_rdata = b_prdata[i*DATA_WD +: DATA_WD];
            end
        end
    end

    always_comb begin
        b_psel    = '0;
        b_penable = 1'b0;
        if (state == SETUP || state == ACCESS) begin
            for (int i = 0; i < NUM_SLV; i++) begin
                if (32'(idx_q) == i) b_psel[i] = 1'b1;
            end
            b_penable = (state == ACCESS);
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_q;
        capture   = 1'b0;
        complete  = 1'b0;
        cpl_err   = 1'b0;
        cpl_rd    = 1'b0;
        // A request arriving mid-transfer is remembered once; a further one is lost.
        if (req_edge && state != IDLE) pend_nxt = 1'b1;
        case (state)
            IDLE: begin
                if (req_edge || pend_q) begin
                    capture   = 1'b1;
                    pend_nxt  = 1'b0;
                    state_nxt = idx_ok ? SETUP : DERR;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (sel_ready) begin
                    complete  = 1'b1;
                    cpl_err   = sel_err;
                    cpl_rd    = ~b_pwrite;
                    state_nxt = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (to_cnt == TO_WD'(TIMEOUT_CYC - 1)) begin
                    complete  = 1'b1;
                    cpl_err   = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            DERR: begin
                complete  = 1'b1;
                cpl_err   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge b_pclk) begin
        if (!b_prst_n) begin
            state       <= IDLE;
            sync_q      <= '0;
            dly_q       <= 1'b0;
            pend_q      <= 1'b0;
            idx_q       <= '0;
            b_pwrite    <= 1'b0;
            b_paddr     <= '0;
            b_pwdata    <= '0;
            b_pprot     <= '0;
            b_pstrb     <= '0;
            b_ready_req <= 1'b0;
            rdata       <= '0;
            slverr      <= 1'b0;
        end else begin
            state  <= state_nxt;
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_apb_req};
            dly_q  <= sync_q[SYNC_STAGES-1];
            pend_q <= pend_nxt;
            if (capture) begin
                idx_q    <= idx_in;
                b_pwrite <= write;
                b_paddr  <= addr;
                b_pwdata <= wdata;
                b_pprot  <= prot;
                b_pstrb  <= strb;
            end
            if (complete) begin
                b_ready_req <= ~b_ready_req;
                slverr      <= cpl_err;
                if (cpl_rd) rdata <= sel_rdata;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge b_pclk) begin
        if (!b_prst_n) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !sel_ready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_apb_lf_master_mux.sv
// Bench for apb_lf_master_mux: transaction-level timing model (windows computed from the request
// cycle) checked every cycle, directed scenarios with literal expectations, then random transfers.
module tb_apb_lf_master_mux;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int PW  = 3;
    localparam int NS  = 3;
    localparam int LSB = 12;
    localparam int SS  = 2;
    localparam int TO  = 8;

    logic             b_pclk = 1'b0;
    logic             b_prst_n = 1'b0;
    logic             a_apb_req = 1'b0;
    logic             write = 1'b0;
    logic [AW-1:0]    addr = '0;
    logic [DW-1:0]    wdata = '0;
    logic [PW-1:0]    prot = '0;
    logic [SW-1:0]    strb = '0;
    logic [NS-1:0]    b_psel;
    logic             b_penable, b_pwrite;
    logic [AW-1:0]    b_paddr;
    logic [DW-1:0]    b_pwdata;
    logic [PW-1:0]    b_pprot;
    logic [SW-1:0]    b_pstrb;
    logic [NS*DW-1:0] b_prdata = '0;
    logic [NS-1:0]    b_pready = '0;
    logic [NS-1:0]    b_pslverr = '0;
    logic             b_ready_req;
    logic [DW-1:0]    rdata;
    logic             slverr;

    apb_lf_master_mux #(
        .ADDR_WD(AW), .DATA_WD(DW), .STRB_WD(SW), .PROT_WD(PW), .NUM_SLV(NS),
        .SLV_LSB(LSB), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)
    ) dut (
        .b_pclk(b_pclk), .b_prst_n(b_prst_n), .a_apb_req(a_apb_req),
        .write(write), .addr(addr), .wdata(wdata), .prot(prot), .strb(strb),
        .b_psel(b_psel), .b_penable(b_penable), .b_pwrite(b_pwrite),
        .b_paddr(b_paddr), .b_pwdata(b_pwdata), .b_pprot(b_pprot), .b_pstrb(b_pstrb),
        .b_prdata(b_prdata), .b_pready(b_pready), .b_pslverr(b_pslverr),
        .b_ready_req(b_ready_req), .rdata(rdata), .slverr(slverr)
    );

    always #5 b_pclk = ~b_pclk;

    int cyc = 0;
    always @(posedge b_pclk) cyc <= cyc + 1;

    // Current transaction: E is the edge after which the detected request pulse is visible.
    bit          m_active = 1'b0;
    bit          m_derr, m_write, m_to, m_err;
    int          m_E, m_done, m_idx;
    logic [31:0] m_rv;

    logic          exp_tog = 1'b0, exp_slverr = 1'b0, exp_pwrite = 1'b0;
    logic [DW-1:0] exp_rdata = '0, exp_pwdata = '0;
    logic [AW-1:0] exp_paddr = '0;
    logic [PW-1:0] exp_pprot = '0;
    logic [SW-1:0] exp_pstrb = '0;
    bit            chk_en = 1'b0;
    int            checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, cyc);
        end
    endtask

    always @(negedge b_pclk) begin
        logic [NS-1:0]    epsel, rdy, err;
        logic             epen;
        logic [NS*DW-1:0] rd;
        bit               inwin;
        inwin = m_active && !m_derr && cyc >= m_E + 1 && cyc < m_done;
        if (chk_en) begin
            if (m_active && cyc == m_E + 1) begin
                exp_pwrite = write; exp_paddr = addr; exp_pwdata = wdata;
                exp_pprot = prot; exp_pstrb = strb;
            end
            if (m_active && cyc == m_done) begin
                exp_tog = ~exp_tog;
                if (m_derr || m_to) exp_slverr = 1'b1;
                else begin
                    exp_slverr = m_err;
                    if (!m_write) exp_rdata = m_rv;
                end
            end
            epsel = '0;
            epen  = 1'b0;
            if (inwin) begin
                epsel[m_idx] = 1'b1;
                epen = (cyc >= m_E + 2);
            end
            chk("psel", 64'(b_psel), 64'(epsel));
            chk("penable", 64'(b_penable), 64'(epen));
            chk("ready_req", 64'(b_ready_req), 64'(exp_tog));
            chk("rdata", 64'(rdata), 64'(exp_rdata));
            chk("slverr", 64'(slverr), 64'(exp_slverr));
            chk("pwrite", 64'(b_pwrite), 64'(exp_pwrite));
            chk("paddr", 64'(b_paddr), 64'(exp_paddr));
            chk("pwdata", 64'(b_pwdata), 64'(exp_pwdata));
            chk("pprot", 64'(b_pprot), 64'(exp_pprot));
            chk("pstrb", 64'(b_pstrb), 64'(exp_pstrb));
        end
        // Unselected completers get noise; the selected one follows the planned wait count.
        rdy = NS'($urandom);
        err = NS'($urandom);
        for (int i = 0; i < NS; i++) rd[i*DW +: DW] = $urandom;
        if (inwin) begin
            rdy[m_idx] = !m_to && (cyc == m_done - 1);
            err[m_idx] = m_err;
            rd[m_idx*DW +: DW] = m_rv;
        end
        b_pready  = rdy;
        b_pslverr = err;
        b_prdata  = rd;
    end

    task automatic do_reset();
        b_prst_n = 1'b0;
        a_apb_req = 1'b0;
        chk_en = 1'b0;
        m_active = 1'b0;
        exp_tog = 1'b0; exp_slverr = 1'b0; exp_pwrite = 1'b0; exp_rdata = '0;
        exp_pwdata = '0; exp_paddr = '0; exp_pprot = '0; exp_pstrb = '0;
        @(posedge b_pclk); #1;
        chk_en = 1'b1;
        @(posedge b_pclk); #1;
        b_prst_n = 1'b1;
    endtask

    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int waits,
                        input bit er, input logic [31:0] rv, input int abort_at);
        int eff;
        bit to;
        @(posedge b_pclk); #2;
        write = wr; addr = a; wdata = wd; strb = st; prot = pr;
        a_apb_req = ~a_apb_req;
        m_E = cyc + 1 + SS - 1;
        m_idx = int'(a[LSB +: 2]);
        m_derr = (m_idx >= NS);
        m_write = wr; m_err = er; m_rv = rv;
        eff = waits;
        to = 1'b0;
`ifdef APB_TIMEOUT_EN
        if (waits > TO - 1) begin eff = TO - 1; to = 1'b1; end
`endif
        m_to = to;
        m_done = m_derr ? m_E + 2 : m_E + 3 + eff;
        m_active = 1'b1;
        if (abort_at >= 0 && !m_derr) begin
            while (cyc < m_E + 2 + abort_at) begin @(posedge b_pclk); #1; end
            do_reset();
        end else begin
            while (cyc < m_done) begin @(posedge b_pclk); #1; end
            @(negedge b_pclk); #1;
            m_active = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          idx;
        do_reset();
        chk("rst_psel", 64'(b_psel), 64'd0);
        chk("rst_ready_req", 64'(b_ready_req), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_paddr", 64'(b_paddr), 64'd0);

        xfer(1'b0, 32'h0000_1004, 32'h0, 4'hF, 3'd0, 0, 1'b0, 32'hDEAD_BEEF, -1);
        chk("t1_rdata", 64'(rdata), 64'hDEAD_BEEF);
        chk("t1_slverr", 64'(slverr), 64'd0);
        chk("t1_ready_req", 64'(b_ready_req), 64'd1);

        xfer(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'b0011, 3'b010, 3, 1'b0, 32'h0BAD_0BAD, -1);
        chk("t2_rdata_kept", 64'(rdata), 64'hDEAD_BEEF);
        chk("t2_pwrite", 64'(b_pwrite), 64'd1);
        chk("t2_pstrb", 64'(b_pstrb), 64'h3);
        chk("t2_pwdata", 64'(b_pwdata), 64'hA5A5_5A5A);

        xfer(1'b0, 32'h0000_3000, 32'h0, 4'hF, 3'd0, 0, 1'b0, 32'h1111_1111, -1);
        chk("t3_slverr", 64'(slverr), 64'd1);
        chk("t3_rdata_kept", 64'(rdata), 64'hDEAD_BEEF);
        chk("t3_ready_req", 64'(b_ready_req), 64'd1);

        xfer(1'b0, 32'h0000_2000, 32'h0, 4'hF, 3'd1, 1, 1'b1, 32'h0000_1234, -1);
        chk("t4_slverr", 64'(slverr), 64'd1);
        chk("t4_rdata", 64'(rdata), 64'h1234);
        xfer(1'b0, 32'h0000_2008, 32'h0, 4'hF, 3'd1, 0, 1'b0, 32'h0000_5678, -1);
        chk("t4b_slverr", 64'(slverr), 64'd0);
        chk("t4b_rdata", 64'(rdata), 64'h5678);

        xfer(1'b0, 32'h0000_1000, 32'h0, 4'hF, 3'd0, 110, 1'b0, 32'hCAFE_0001, -1);
`ifdef APB_TIMEOUT_EN
        chk("t5_to_slverr", 64'(slverr), 64'd1);
        chk("t5_to_rdata", 64'(rdata), 64'h5678);
`else
        chk("t5_slverr", 64'(slverr), 64'd0);
        chk("t5_rdata", 64'(rdata), 64'hCAFE_0001);
`endif

        xfer(1'b1, 32'h0000_1000, 32'h1357_9BDF, 4'hF, 3'd0, 50, 1'b0, 32'h0, 2);
        chk("t6_psel", 64'(b_psel), 64'd0);
        chk("t6_penable", 64'(b_penable), 64'd0);
        chk("t6_ready_req", 64'(b_ready_req), 64'd0);
        xfer(1'b0, 32'h0000_0000, 32'h0, 4'hF, 3'd0, 0, 1'b0, 32'h0000_0077, -1);
        chk("t6b_rdata", 64'(rdata), 64'h77);
        chk("t6b_ready_req", 64'(b_ready_req), 64'd1);

        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 3);
            a = $urandom;
            a[LSB +: 2] = 2'(idx);
            xfer(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom),
                 $urandom_range(0, 4), 1'($urandom), $urandom, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
